// File: rtl/xcvr_tx_width_gearbox.sv
// Wide-to-narrow TX gearbox: buffers IN_W-bit words in a FIFO and serialises them
// LSB lane first onto the transceiver lane, substituting IDLE_WORD when starved.
module xcvr_tx_width_gearbox #(
  parameter int               OUT_W     = 64,
  parameter int               RATIO     = 2,
  parameter int               DEPTH     = 16,
  parameter logic [OUT_W-1:0] IDLE_WORD = {8{8'h07}},
  parameter int               CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [OUT_W*RATIO-1:0]     in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       tx_enable,
  output logic [OUT_W-1:0]           tx_data,
  output logic                       tx_data_valid,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [CNT_W-1:0]           underflow_count,
  output logic                       underflow_sticky,
  input  logic                       clear_stats
);

  localparam int IN_W  = OUT_W * RATIO;
  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic {ST_EMPTY, ST_SHIFT} state_t;

  logic [IN_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [IN_W-1:0]  rd_word;
  logic [IN_W-1:0]  word_reg;
  logic [OUT_W-1:0] held_lane [RATIO];

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [OUT_W-1:0] tx_data_reg, tx_data_next;
  logic             tx_valid_reg, tx_valid_next;
  logic             primed_reg;
  logic [CNT_W-1:0] ucnt_reg;
  logic             sticky_reg;

  logic push, pop, underflow;

  assign fifo_full        = (count_reg == (AW+1)'(DEPTH));
  assign fifo_empty       = (count_reg == '0);
  assign fill_level       = count_reg;
  assign in_ready         = !fifo_full && !reset;
  assign push             = in_valid && in_ready;
  assign rd_word          = mem[rd_ptr_reg];
  assign tx_data          = tx_data_reg;
  assign tx_data_valid    = tx_valid_reg;
  assign underflow_count  = ucnt_reg;
  assign underflow_sticky = sticky_reg;

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      assign held_lane[gi] = word_reg[gi*OUT_W +: OUT_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Lane 0 of a freshly popped word goes straight out; the word is kept for the rest.
  always_ff @(posedge clk) begin
    if (pop) word_reg <= rd_word;
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    pop           = 1'b0;
    underflow     = 1'b0;
    if (tx_enable) begin
      case (state_reg)
        ST_EMPTY: begin
          if (!fifo_empty) begin
            pop           = 1'b1;
            tx_data_next  = rd_word[OUT_W-1:0];
            tx_valid_next = 1'b1;
            if (RATIO > 1) begin
              state_next = ST_SHIFT;
              idx_next   = IDX_W'(1);
            end
          end else begin
            underflow     = 1'b1;
            tx_data_next  = IDLE_WORD;
            tx_valid_next = 1'b0;
          end
        end
        ST_SHIFT: begin
          tx_data_next  = held_lane[idx_reg];
          tx_valid_next = 1'b1;
          if (idx_reg == LAST_IDX) begin
            idx_next = '0;
            // Prefetch the next word alongside the last lane so the stream has no bubble.
            if (!fifo_empty) pop = 1'b1;
            else             state_next = ST_EMPTY;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
        default: begin
          state_next = ST_EMPTY;
          idx_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_EMPTY;
      idx_reg      <= '0;
      tx_data_reg  <= IDLE_WORD;
      tx_valid_reg <= 1'b0;
      primed_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      if (pop) primed_reg <= 1'b1;
    end
  end

  // Filler before the first real word is expected start-up behaviour, not an underflow.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      ucnt_reg   <= '0;
      sticky_reg <= 1'b0;
    end else if (underflow && primed_reg) begin
      sticky_reg <= 1'b1;
      if (ucnt_reg != '1) ucnt_reg <= ucnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xcvr_tx_width_gearbox.sv
// Directed bench for xcvr_tx_width_gearbox: queue-based model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_xcvr_tx_width_gearbox;

  localparam int OUT_W = 64;
  localparam int RATIO = 2;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam logic [OUT_W-1:0] IDLE = {8{8'h07}};

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [OUT_W*RATIO-1:0] in_data = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic                  tx_enable = 1'b0;
  logic [OUT_W-1:0]      tx_data;
  logic                  tx_data_valid;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fill_level;
  logic [CNT_W-1:0]      underflow_count;
  logic                  underflow_sticky;
  logic                  clear_stats = 1'b0;

  xcvr_tx_width_gearbox #(
    .OUT_W(OUT_W), .RATIO(RATIO), .DEPTH(DEPTH), .IDLE_WORD(IDLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_enable(tx_enable), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fill_level(fill_level),
    .underflow_count(underflow_count), .underflow_sticky(underflow_sticky),
    .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  // Model: words waiting in the FIFO, and lanes still to send from the held word.
  logic [OUT_W*RATIO-1:0] q[$];
  logic [OUT_W-1:0]       held[$];
  logic [OUT_W-1:0]       exp_data;
  logic                   exp_valid;
  logic [CNT_W-1:0]       exp_cnt;
  logic                   exp_sticky;
  logic                   primed;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic take_word();
    logic [OUT_W*RATIO-1:0] w;
    w = q.pop_front();
    for (int k = 0; k < RATIO; k++) held.push_back(w[k*OUT_W +: OUT_W]);
    primed = 1'b1;
  endtask

  task automatic model_edge();
    int pre;
    if (reset) begin
      q.delete(); held.delete();
      exp_data = IDLE; exp_valid = 1'b0; primed = 1'b0;
      exp_cnt = '0; exp_sticky = 1'b0;
      return;
    end
    pre = q.size();
    if (tx_enable) begin
      if (held.size() > 0) begin
        exp_data = held.pop_front(); exp_valid = 1'b1;
        if (held.size() == 0 && pre > 0) take_word();
      end else if (pre > 0) begin
        take_word();
        exp_data = held.pop_front(); exp_valid = 1'b1;
      end else begin
        exp_data = IDLE; exp_valid = 1'b0;
        if (primed) begin
          exp_sticky = 1'b1;
          if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
    if (clear_stats) begin exp_cnt = '0; exp_sticky = 1'b0; end
    if (in_valid && pre < DEPTH) q.push_back(in_data);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    $display("cyc %0d rst %b en %b vin %b rdy %b data %h v %b fill %0d ucnt %0d st %b",
             cyc, reset, tx_enable, in_valid, in_ready, tx_data, tx_data_valid,
             fill_level, underflow_count, underflow_sticky);
    check("tx_data", tx_data, exp_data);
    check("tx_data_valid", tx_data_valid, exp_valid);
    check("fill_level", fill_level, q.size());
    check("fifo_empty", fifo_empty, q.size() == 0);
    check("fifo_full", fifo_full, q.size() == DEPTH);
    check("underflow_count", underflow_count, exp_cnt);
    check("underflow_sticky", underflow_sticky, exp_sticky);
    check("in_ready", in_ready, (q.size() < DEPTH) && !reset);
  endtask

  function automatic logic [127:0] mkword(input int i);
    logic [63:0] lo, hi;
    lo = 64'hA000_0000_0000_0000 | 64'(i);
    hi = 64'hB000_0000_0000_0000 | 64'(i);
    return {hi, lo};
  endfunction

  initial begin
    // Reset, then idle with the transceiver enabled: filler is not counted.
    reset = 1'b1;
    step(); step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_tx_data", tx_data, IDLE);
    check("rst_fill", fill_level, 0);
    reset = 1'b0;
    tx_enable = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("idle_data", tx_data, IDLE);
    check("idle_cnt", underflow_count, 0);

    // Latency and lane order.
    in_data = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_nonempty", fifo_empty, 1'b0);
    step();
    check("lat_lane0", tx_data, 64'h2222_2222_2222_2222);
    check("lat_lane0_v", tx_data_valid, 1'b1);
    step();
    check("lat_lane1", tx_data, 64'h1111_1111_1111_1111);
    step();
    check("lat_idle", tx_data, IDLE);
    check("lat_idle_v", tx_data_valid, 1'b0);
    check("lat_cnt", underflow_count, 1);
    tx_enable = 1'b0;

    // Fill to full with TX stalled, 17th word refused, then drain gap-free.
    for (int i = 0; i < 17; i++) begin
      in_data = mkword(i); in_valid = 1'b1;
      step();
      if (i == 15) begin
        check("full_rdy", in_ready, 1'b0);
        check("full_fill", fill_level, 16);
      end
    end
    in_valid = 1'b0;
    tx_enable = 1'b1;
    for (int i = 0; i < 33; i++) begin
      step();
      if (i == 31) check("drain_last", tx_data, 64'hB000_0000_0000_000F);
    end
    tx_enable = 1'b0;

    // Stall mid-word.
    in_data = mkword(40); in_valid = 1'b1;
    step();
    in_valid = 1'b0; tx_enable = 1'b1;
    step();
    check("stall_lane0", tx_data, 64'hA000_0000_0000_0028);
    tx_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_data = mkword(41); in_valid = 1'b1; end
      else in_valid = 1'b0;
      step();
    end
    in_valid = 1'b0;
    check("stall_hold", tx_data, 64'hA000_0000_0000_0028);
    tx_enable = 1'b1;
    step();
    check("stall_lane1", tx_data, 64'hB000_0000_0000_0028);
    step();
    check("stall_next", tx_data, 64'hA000_0000_0000_0029);
    step();
    tx_enable = 1'b0;

    // Statistics: counting, clear priority, saturation.
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("clr_cnt", underflow_count, 0);
    tx_enable = 1'b1;
    step(); step(); step();
    check("stat_cnt3", underflow_count, 3);
    check("stat_sticky", underflow_sticky, 1'b1);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("clr_wins_cnt", underflow_count, 0);
    check("clr_wins_sticky", underflow_sticky, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt", underflow_count, 15);
    tx_enable = 1'b0;

    // Reset mid-word with four words queued.
    for (int i = 0; i < 5; i++) begin
      in_data = mkword(60 + i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; tx_enable = 1'b1;
    step();
    check("mid_lane0", tx_data, 64'hA000_0000_0000_003C);
    check("mid_fill", fill_level, 4);
    reset = 1'b1;
    step();
    check("mid_rst_data", tx_data, IDLE);
    check("mid_rst_empty", fifo_empty, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("mid_no_stale", tx_data_valid, 1'b0);

    // Source at exactly one word per RATIO enabled cycles.
    for (int i = 0; i < 16; i++) begin
      in_data = mkword(80 + i); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
    end
    check("stream_cnt", underflow_count, 0);
    for (int i = 0; i < 4; i++) step();
    tx_enable = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/xcvr_tx_width_gearbox.md
# xcvr_tx_width_gearbox

Single-clock, parametrised TX width gearbox between a wide data source (pattern generator or user logic) and a narrow transceiver TX parallel interface. Input words of RATIO×OUT_W bits are buffered in an internal FIFO and serialised LSB-lane-first, one OUT_W lane per transceiver-enabled cycle. On starvation it substitutes a programmable idle word instead of stalling. Saturating underflow statistics are maintained for the test system's status registers.

## Interface
- OUT_W, 64: transceiver lane width in bits.
- RATIO, 2: lanes per input word; IN_W = OUT_W*RATIO; legal 1..8.
- DEPTH, 16: FIFO depth in input words; power of 2, ≥2.
- IDLE_WORD, {8{8'h07}}: OUT_W-bit filler driven on underflow and after reset.
- CNT_W, 16: underflow counter width.

- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- in_data  in  IN_W  input word; lane k = bits [k*OUT_W +: OUT_W].
- in_valid  in  1  input word valid.
- in_ready  out  1  = !fifo_full && !reset; no combinational path from tx_enable.
- tx_enable  in  1  transceiver consumes one lane this cycle.
- tx_data  out  OUT_W  registered lane output.
- tx_data_valid  out  1  registered; 1 = real data, 0 = IDLE_WORD filler.
- fifo_full  out  1  FIFO holds DEPTH words.
- fifo_empty  out  1  FIFO holds 0 words.
- fill_level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- underflow_count  out  CNT_W  saturating count of underflow cycles.
- underflow_sticky  out  1  set on first underflow, held until cleared.
- clear_stats  in  1  synchronous clear of underflow_count and underflow_sticky.

## Operation
- Push: in_valid && in_ready writes in_data at the clock edge; fill_level increments.
- Serialiser states: EMPTY (no word held) and SHIFT (word held, lane index 0..RATIO-1). Primed flag is set on the first pop after reset.
- On a tx_enable cycle:
  - EMPTY: if FIFO is non-empty, pop, drive lane 0, enter SHIFT with index 1; if RATIO=1, remain ready to pop again.
  - SHIFT with index < RATIO-1: drive lane[index], index++.
  - SHIFT with index = RATIO-1: drive the last lane; pop the next word in the same cycle if available (no bubble), otherwise return to EMPTY.
- Underflow: tx_enable=1 in EMPTY with the FIFO empty. Drive IDLE_WORD with tx_data_valid=0. If primed, increment underflow_count (saturates at all-ones) and set underflow_sticky. Before the first pop, filler is not counted.
- tx_enable=0: tx_data, tx_data_valid, lane index and FIFO read side all hold. Pushes still proceed.
- Simultaneous push and pop: fill_level unchanged. Push is blocked when full even if a pop occurs in the same cycle.
- clear_stats: counter and sticky go to 0 and clear wins over a coincident underflow. primed is not cleared.
- Reset mid-word: any partially sent word and all FIFO contents are discarded.

## Timing
- Reset values: tx_data=IDLE_WORD, tx_data_valid=0, fifo_empty=1, fifo_full=0, fill_level=0, underflow_count=0, underflow_sticky=0, in_ready=0 during reset and 1 in the first cycle after. Serialiser is EMPTY and primed=0.
- Latency: a word pushed at edge N makes fifo_empty=0 in cycle N+1. With tx_enable held high, lane 0 appears on tx_data in cycle N+2 and lane k in cycle N+2+k.
- Sustained throughput is one lane per tx_enable cycle. The source must supply ≥1 word per RATIO enabled cycles to avoid underflow.
- Status outputs (fifo_full, fifo_empty, fill_level) reflect state after the previous edge. The counter updates one cycle after the underflow cycle.

## Test plan
- Reset then idle: tx_enable=1 with no input for 20 cycles -> tx_data=IDLE_WORD, tx_data_valid=0, underflow_count=0 (not primed).
- Latency and order (RATIO=2): push 128'h1111…_2222… at edge 0 with tx_enable high -> cycle 2 tx_data=64'h2222… (low lane), cycle 3 tx_data=64'h1111…, both with valid=1. Cycle 4 shows IDLE_WORD, valid=0, and underflow_count=1.
- Full/back-pressure: hold tx_enable=0 and push 17 words with DEPTH=16 -> in_ready=0 after 16 pushes, fill_level=16, 17th word not accepted. Enabling TX then drains 32 lanes in order, gap-free.
- Stall mid-word: drop tx_enable for 5 cycles after lane 0 -> tx_data holds lane 0, then lane 1 follows with no loss or duplication.
- Stats: force 3 underflow cycles after priming -> count=3, sticky=1. clear_stats coincident with a 4th underflow -> count=0, sticky=0. With CNT_W=4, 20 underflows -> count=15 (saturated).
- Reset mid-word: assert reset after lane 0 with 4 words queued -> next cycle matches reset values and no stale lanes are emitted afterwards.
